// File: rtl/ram_stream_reader.sv
// ram_stream_reader
// -----------------
// Read initiator for one port of a pipelined dual-port URAM bank. A command
// (base address, word count) is turned into one read per cycle on the bank
// port. Returning data is realigned with a fixed read latency and delivered as
// a valid/ready stream with a last marker. Reads are only issued while there
// is guaranteed room for their data, so backpressure never drops a word that
// is already in flight from the RAM.
//
// Optional feature (compile-time macro RAM_STREAM_READER_STRIDE_EN):
//   defined   : adds cmd_stride; the address advances by the stride
//               (modulo 2^AWIDTH). A stride of 0 re-reads one word.
//   undefined : no cmd_stride port; the address advances by 1.
//
// Ports
//   clk, rst          clock and synchronous active-high reset
//   cmd_valid/ready   command handshake
//   cmd_addr          first word address
//   cmd_len           word count, 0..2^AWIDTH
//   cmd_stride        address step (only with RAM_STREAM_READER_STRIDE_EN)
//   ram_addr/ce/we/d  RAM port drive (ram_we and ram_d are constant 0)
//   ram_q             RAM read data, valid READ_LAT cycles after ram_ce
//   out_data/valid/ready/last  output stream
//   busy              high whenever the controller is not idle
//   done              one-cycle pulse when a command completes

module ram_stream_reader #(
    parameter int AWIDTH     = 12,
    parameter int DWIDTH     = 64,
    parameter int READ_LAT   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [AWIDTH-1:0] cmd_addr,
    input  logic [AWIDTH:0]   cmd_len,
`ifdef RAM_STREAM_READER_STRIDE_EN
    input  logic [AWIDTH-1:0] cmd_stride,
`endif
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_d,
    output logic              ram_ce,
    output logic              ram_we,
    input  logic [DWIDTH-1:0] ram_q,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int PW = $clog2(FIFO_DEPTH);
    // Wide enough to hold ram_ce + return pipe + FIFO occupancy.
    localparam int OW = $clog2(FIFO_DEPTH + READ_LAT + 2) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [AWIDTH-1:0]   cur_addr_reg;
    logic [AWIDTH:0]     remaining_reg;
    logic [AWIDTH:0]     rx_remaining_reg;
    logic [AWIDTH-1:0]   step;
    logic                ram_ce_reg;
    logic [AWIDTH-1:0]   ram_addr_reg;
    logic [READ_LAT-1:0] vpipe_reg;

    logic [DWIDTH:0]     fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr_reg, rd_ptr_reg;
    logic [PW:0]         fifo_count_reg;

    logic                accept, issue, push, pop, rx_last, pipe_idle, credit_ok;
    logic [OW-1:0]       inflight, occupancy;

`ifdef RAM_STREAM_READER_STRIDE_EN
    logic [AWIDTH-1:0]   stride_reg;
    assign step = stride_reg;
`else
    assign step = AWIDTH'(1);
`endif

    assign ram_addr  = ram_addr_reg;
    assign ram_ce    = ram_ce_reg;
    assign ram_we    = 1'b0;
    assign ram_d     = '0;

    // First-word fall-through FIFO: head entry is presented combinationally.
    assign out_valid = (fifo_count_reg != '0);
    assign out_data  = fifo_mem[rd_ptr_reg][DWIDTH-1:0];
    assign out_last  = fifo_mem[rd_ptr_reg][DWIDTH];
    assign pop       = out_valid & out_ready;
    assign push      = vpipe_reg[READ_LAT-1];
    // The word being pushed is the cmd_len-th of the command when one is left.
    assign rx_last   = (rx_remaining_reg == (AWIDTH+1)'(1));
    assign pipe_idle = !ram_ce_reg && (vpipe_reg == '0);

    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);

    // Credit: every read on the wire, in the return pipe or already buffered
    // owns one FIFO slot. A pop in this cycle frees a slot for the read being
    // registered now, which is what lets a 4-entry buffer sustain 1 word/cycle.
    always_comb begin
        inflight = OW'(ram_ce_reg);
        for (int i = 0; i < READ_LAT; i++) begin
            inflight = inflight + OW'(vpipe_reg[i]);
        end
        occupancy = inflight + OW'(fifo_count_reg) - OW'(pop);
        credit_ok = (occupancy < OW'(FIFO_DEPTH));
    end

    always_comb begin
        state_next = state_reg;
        cmd_ready  = 1'b0;
        accept     = 1'b0;
        issue      = 1'b0;
        case (state_reg)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept     = 1'b1;
                    state_next = (cmd_len != '0) ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                if ((remaining_reg != '0) && credit_ok) begin
                    issue = 1'b1;
                    if (remaining_reg == (AWIDTH+1)'(1)) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The last word leaving the FIFO empties the whole path.
                if (pipe_idle && pop && out_last && (fifo_count_reg == (PW+1)'(1))) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            cur_addr_reg     <= '0;
            remaining_reg    <= '0;
            rx_remaining_reg <= '0;
            ram_ce_reg       <= 1'b0;
            ram_addr_reg     <= '0;
            vpipe_reg        <= '0;
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            fifo_count_reg   <= '0;
`ifdef RAM_STREAM_READER_STRIDE_EN
            stride_reg       <= AWIDTH'(1);
`endif
        end else begin
            state_reg  <= state_next;
            ram_ce_reg <= issue;

            if (accept) begin
                cur_addr_reg     <= cmd_addr;
                remaining_reg    <= cmd_len;
                rx_remaining_reg <= cmd_len;
`ifdef RAM_STREAM_READER_STRIDE_EN
                stride_reg       <= cmd_stride;
`endif
            end

            if (issue) begin
                ram_addr_reg  <= cur_addr_reg;
                cur_addr_reg  <= cur_addr_reg + step;
                remaining_reg <= remaining_reg - (AWIDTH+1)'(1);
            end

            // Valid bits shadow the RAM pipeline so returning data is
            // captured exactly READ_LAT cycles after its ram_ce.
            vpipe_reg[0] <= ram_ce_reg;
            for (int i = 1; i < READ_LAT; i++) begin
                vpipe_reg[i] <= vpipe_reg[i-1];
            end

            if (push) begin
                wr_ptr_reg       <= wr_ptr_reg + PW'(1);
                rx_remaining_reg <= rx_remaining_reg - (AWIDTH+1)'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count_reg <= fifo_count_reg + (PW+1)'(1);
                2'b01:   fifo_count_reg <= fifo_count_reg - (PW+1)'(1);
                default: fifo_count_reg <= fifo_count_reg;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {rx_last, ram_q};
        end
    end

endmodule
